// File: rtl/mips_stage_sequencer.sv
// mips_stage_sequencer: one-hot N-stage strobe sequencer with clock divider, stall, interrupt latch and instruction counter
// Ports: Input_Clk (rising-edge clock), Reset_n (sync active-low reset), Stall (freeze sequencing),
//   Interrupt (rising-edge request), Stage_En (one-hot stage strobe), Stage_Idx (binary stage index),
//   Irq_Pending (latched request), Irq_Ack (one-cycle take pulse), Instr_Count (completed instruction cycles).
// Optional MIPS_SEQ_SINGLE_STEP_EN adds Step: after each wrap the sequencer parks at stage 0 until Step=1.
module mips_stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int DIV        = 1,
  parameter int CNT_W      = 8,
  parameter int IDX_W      = 3
) (
  input  logic                  Input_Clk,
  input  logic                  Reset_n,
  input  logic                  Stall,
  input  logic                  Interrupt,
`ifdef MIPS_SEQ_SINGLE_STEP_EN
  input  logic                  Step,
`endif
  output logic [NUM_STAGES-1:0] Stage_En,
  output logic [IDX_W-1:0]      Stage_Idx,
  output logic                  Irq_Pending,
  output logic                  Irq_Ack,
  output logic [CNT_W-1:0]      Instr_Count
);
  localparam int DIV_W = DIV > 1 ? $clog2(DIV) : 1;
  logic [DIV_W-1:0] div_cnt;
  logic irq_prev, irq_edge, run, adv, wrap;
`ifdef MIPS_SEQ_SINGLE_STEP_EN
  logic held;
  always_comb run = ~Stall & (~held | Step);
`else
  always_comb run = ~Stall;
`endif
  always_comb begin
    irq_edge = Interrupt & ~irq_prev;
    adv      = run && div_cnt == DIV_W'(DIV - 1);
    wrap     = adv && Stage_Idx == IDX_W'(NUM_STAGES - 1);
  end
  always_ff @(posedge Input_Clk) begin
    if (!Reset_n) begin
      div_cnt     <= '0;
      Stage_En    <= NUM_STAGES'(1);
      Stage_Idx   <= '0;
      Irq_Pending <= 1'b0;
      Irq_Ack     <= 1'b0;
      Instr_Count <= '0;
      irq_prev    <= 1'b0;
    end else begin
      irq_prev    <= Interrupt;
      Irq_Ack     <= wrap & Irq_Pending;
      // a fresh edge on the take cycle re-arms the request for the next wrap
      Irq_Pending <= irq_edge | (Irq_Pending & ~wrap);
      if (run) div_cnt <= adv ? '0 : div_cnt + 1'b1;
      if (adv) begin
        Stage_En  <= wrap ? NUM_STAGES'(1) : {Stage_En[NUM_STAGES-2:0], 1'b0};
        Stage_Idx <= wrap ? '0 : Stage_Idx + 1'b1;
      end
      if (wrap) Instr_Count <= Instr_Count + 1'b1;
    end
  end
`ifdef MIPS_SEQ_SINGLE_STEP_EN
  // park after every wrap; the Step clock releases the hold and starts the next instruction
  always_ff @(posedge Input_Clk) begin
    if (!Reset_n) held <= 1'b0;
    else          held <= wrap | (held & ~run);
  end
`endif
endmodule

// File: tb/tb_mips_stage_sequencer.sv
// tb_mips_stage_sequencer: directed table, corner sequences and randomized model checks for mips_stage_sequencer
module tb_mips_stage_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0, stall = 1'b0, irq = 1'b0;
  logic [4:0] en_a, en_b;
  logic [2:0] idx_a, idx_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic pend_a, pend_b, ack_a, ack_b;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mips_stage_sequencer #(.NUM_STAGES(5), .DIV(1), .CNT_W(8), .IDX_W(3)) dut_a (
    .Input_Clk(clk), .Reset_n(rst_n), .Stall(stall), .Interrupt(irq),
    .Stage_En(en_a), .Stage_Idx(idx_a), .Irq_Pending(pend_a), .Irq_Ack(ack_a), .Instr_Count(cnt_a));

  mips_stage_sequencer #(.NUM_STAGES(5), .DIV(3), .CNT_W(2), .IDX_W(3)) dut_b (
    .Input_Clk(clk), .Reset_n(rst_n), .Stall(stall), .Interrupt(irq),
    .Stage_En(en_b), .Stage_Idx(idx_b), .Irq_Pending(pend_b), .Irq_Ack(ack_b), .Instr_Count(cnt_b));

  // reference: count unstalled clocks since reset; stage and count follow by division
  int  ticks [2];
  bit  m_pend [2];
  bit  m_ack [2];
  bit  m_prev;

  function automatic int dv(input int i);
    return i == 0 ? 1 : 3;
  endfunction

  function automatic int cmod(input int i);
    return i == 0 ? 256 : 4;
  endfunction

  task automatic model_update();
    bit wr;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        ticks[i] = 0; m_pend[i] = 0; m_ack[i] = 0;
      end else begin
        wr = !stall && ((ticks[i] + 1) % (5 * dv(i)) == 0);
        m_ack[i]  = wr && m_pend[i];
        m_pend[i] = (irq && !m_prev) || (m_pend[i] && !wr);
        if (!stall) ticks[i]++;
      end
    end
    m_prev = rst_n ? irq : 1'b0;
  endtask

  task automatic step(input bit r, input bit s, input bit q);
    @(negedge clk);
    rst_n = r; stall = s; irq = q;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit r, s, q;
    logic [4:0] en;
    logic [2:0] idx;
    logic [7:0] cnt;
    bit p, a;
  } vec_t;

  vec_t tbl [30];

  function automatic vec_t mk(bit r, bit s, bit q, logic [4:0] en, logic [2:0] idx,
                              logic [7:0] cnt, bit p, bit a);
    vec_t v;
    v.r = r; v.s = s; v.q = q; v.en = en; v.idx = idx; v.cnt = cnt; v.p = p; v.a = a;
    return v;
  endfunction

  initial begin
    int st;
    tbl[0]  = mk(0,0,0, 5'b00001, 0, 0, 0, 0);
    tbl[1]  = mk(0,0,0, 5'b00001, 0, 0, 0, 0);
    tbl[2]  = mk(1,0,0, 5'b00010, 1, 0, 0, 0);
    tbl[3]  = mk(1,0,0, 5'b00100, 2, 0, 0, 0);
    tbl[4]  = mk(1,0,0, 5'b01000, 3, 0, 0, 0);
    tbl[5]  = mk(1,0,0, 5'b10000, 4, 0, 0, 0);
    tbl[6]  = mk(1,0,0, 5'b00001, 0, 1, 0, 0);
    tbl[7]  = mk(1,0,0, 5'b00010, 1, 1, 0, 0);
    tbl[8]  = mk(1,0,1, 5'b00100, 2, 1, 1, 0);
    tbl[9]  = mk(1,0,1, 5'b01000, 3, 1, 1, 0);
    tbl[10] = mk(1,0,0, 5'b10000, 4, 1, 1, 0);
    tbl[11] = mk(1,0,0, 5'b00001, 0, 2, 0, 1);
    tbl[12] = mk(1,0,0, 5'b00010, 1, 2, 0, 0);
    tbl[13] = mk(1,0,0, 5'b00100, 2, 2, 0, 0);
    tbl[14] = mk(1,1,0, 5'b00100, 2, 2, 0, 0);
    tbl[15] = mk(1,1,0, 5'b00100, 2, 2, 0, 0);
    tbl[16] = mk(1,1,0, 5'b00100, 2, 2, 0, 0);
    tbl[17] = mk(1,1,0, 5'b00100, 2, 2, 0, 0);
    tbl[18] = mk(1,0,1, 5'b01000, 3, 2, 1, 0);
    tbl[19] = mk(1,0,0, 5'b10000, 4, 2, 1, 0);
    tbl[20] = mk(1,0,1, 5'b00001, 0, 3, 1, 1);
    tbl[21] = mk(1,0,0, 5'b00010, 1, 3, 1, 0);
    tbl[22] = mk(1,0,0, 5'b00100, 2, 3, 1, 0);
    tbl[23] = mk(1,0,0, 5'b01000, 3, 3, 1, 0);
    tbl[24] = mk(1,0,0, 5'b10000, 4, 3, 1, 0);
    tbl[25] = mk(1,0,0, 5'b00001, 0, 4, 0, 1);
    tbl[26] = mk(1,0,0, 5'b00010, 1, 4, 0, 0);
    tbl[27] = mk(1,0,0, 5'b00100, 2, 4, 0, 0);
    tbl[28] = mk(1,0,0, 5'b01000, 3, 4, 0, 0);
    tbl[29] = mk(0,0,1, 5'b00001, 0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].q);
      chk($sformatf("tbl%0d en", i),   32'(en_a),   32'(tbl[i].en));
      chk($sformatf("tbl%0d idx", i),  32'(idx_a),  32'(tbl[i].idx));
      chk($sformatf("tbl%0d cnt", i),  32'(cnt_a),  32'(tbl[i].cnt));
      chk($sformatf("tbl%0d pend", i), 32'(pend_a), 32'(tbl[i].p));
      chk($sformatf("tbl%0d ack", i),  32'(ack_a),  32'(tbl[i].a));
    end

    // DIV=3: each stage held 3 clocks, CNT_W=2 count wraps 3 -> 0
    step(0,0,0);
    step(0,0,0);
    for (int k = 1; k <= 75; k++) begin
      step(1,0,0);
      st = (k / 3) % 5;
      chk($sformatf("div3 k%0d en", k), 32'(en_b), 32'(1) << st);
      chk($sformatf("div3 k%0d idx", k), 32'(idx_b), 32'(st));
      if (k % 15 == 0) chk($sformatf("div3 k%0d cnt", k), 32'(cnt_b), 32'((k / 15) % 4));
    end

    // DIV=3 stall mid-stage resumes at the same divider phase
    step(0,0,0);
    for (int k = 1; k <= 7; k++) step(1,0,0);
    for (int k = 0; k < 4; k++) begin
      step(1,1,0);
      chk("stall en", 32'(en_b), 32'b00100);
    end
    step(1,0,0);
    chk("resume hold", 32'(en_b), 32'b00100);
    step(1,0,0);
    chk("resume adv", 32'(en_b), 32'b01000);

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 40) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      for (int i = 0; i < 2; i++) begin
        st = (ticks[i] / dv(i)) % 5;
        chk($sformatf("rnd%0d/%0d en", n, i),   32'(i == 0 ? en_a : en_b),   32'(1) << st);
        chk($sformatf("rnd%0d/%0d idx", n, i),  32'(i == 0 ? idx_a : idx_b), 32'(st));
        chk($sformatf("rnd%0d/%0d cnt", n, i),  i == 0 ? 32'(cnt_a) : 32'(cnt_b),
            32'((ticks[i] / (5 * dv(i))) % cmod(i)));
        chk($sformatf("rnd%0d/%0d pend", n, i), 32'(i == 0 ? pend_a : pend_b), 32'(m_pend[i]));
        chk($sformatf("rnd%0d/%0d ack", n, i),  32'(i == 0 ? ack_a : ack_b),   32'(m_ack[i]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_stage_sequencer.md
Name: mips_stage_sequencer

Overview:
- Parametrised successor to the fixed five-phase clock scheme (Clk1..Clk5) of the 8-bit MIPS core.
- Generates one-hot stage-enable strobes for an N-stage datapath from a single Input_Clk, with a programmable clock divider and a pipeline stall.
- Latches interrupt requests and services them only at an instruction boundary.
- Counts completed instruction cycles for the debug/simulation ports.

Parameters:
- NUM_STAGES, 5: number of stage strobes. Legal range ≥2.
- DIV, 1: Input_Clk cycles per stage. Legal range ≥1.
- CNT_W, 8: width of the instruction-cycle counter.
- IDX_W, 3: width of Stage_Idx. Must satisfy 2^IDX_W ≥ NUM_STAGES.

Ports:
- Input_Clk  in  1  system clock. All logic is on the rising edge.
- Reset_n  in  1  synchronous reset, active-low.
- Stall  in  1  freezes sequencing while high.
- Interrupt  in  1  external interrupt request, rising-edge sensitive.
- Stage_En  out  NUM_STAGES  one-hot stage strobe.
- Stage_Idx  out  IDX_W  binary index of the active stage.
- Irq_Pending  out  1  a latched interrupt is awaiting service.
- Irq_Ack  out  1  one-cycle pulse when the interrupt is taken.
- Instr_Count  out  CNT_W  completed instruction cycles.

Behaviour:
- Reset: on a rising Input_Clk edge with Reset_n=0:
  - Stage_En = 1 (stage 0), Stage_Idx = 0.
  - Internal divider count = 0.
  - Irq_Pending = 0, Irq_Ack = 0, Instr_Count = 0.
  - The interrupt edge-detect register is set to 0.
  - Reset overrides every other input and may arrive mid-sequence; there is no partial state retained.
- Divider:
  - When Stall=0, div_cnt increments each clock.
  - At div_cnt == DIV-1 it returns to 0 and an "advance" occurs.
  - DIV=1 means advance on every unstalled clock.
- Stall:
  - Stall=1 holds div_cnt, Stage_En, Stage_Idx and Instr_Count unchanged.
  - Interrupt edge capture still operates during Stall.
- Advance, not at the last stage: Stage_En rotates left by one; Stage_Idx increments.
- Advance at the last stage (Stage_Idx == NUM_STAGES-1) is a "wrap":
  - Stage_En returns to 1 and Stage_Idx returns to 0.
  - Instr_Count increments modulo 2^CNT_W; 2^CNT_W-1 wraps to 0 with no flag.
- Interrupt capture:
  - A rising edge is detected when Interrupt=1 and the previous-cycle sample was 0.
  - A detected edge sets Irq_Pending.
  - Multiple edges while pending collapse into one request.
- Interrupt take:
  - When a wrap occurs with Irq_Pending=1, Irq_Ack is high for exactly the next cycle and Irq_Pending clears.
  - Irq_Ack is registered: it rises one clock after the wrap edge, coincident with stage 0 being active.
  - If a new rising edge arrives in the same cycle as the take, Irq_Pending stays 1. The new request is served at the next wrap.
- Stage_En is always exactly one-hot outside reset, and Stage_Idx always matches it.
- Latency:
  - One full instruction cycle = NUM_STAGES*DIV unstalled clocks.
  - Worst-case interrupt service latency = NUM_STAGES*DIV unstalled clocks plus stall time.

Optional Feature:
- MIPS_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input port Step (1 bit).
  - After each wrap, the sequencer holds at stage 0 with div_cnt=0 (behaves as if stalled).
  - It resumes only on a clock where Step=1.
  - Step is ignored while not held.
  - Irq_Ack and Instr_Count behave as normal at the wrap.
  - Reset clears the hold, so the first instruction runs without Step.
- When undefined: no Step port, and sequencing is free-running as described above.

Test Plan:
- Reset_n=0 for 2 clocks, then 1, NUM_STAGES=5, DIV=1 -> Stage_En sequence 00001, 00010, 00100, 01000, 10000, 00001. Instr_Count = 1 after the 5th advance.
- DIV=3 -> each Stage_En value held exactly 3 clocks. Instr_Count = 2 after 30 clocks.
- Stall=1 for 4 clocks while Stage_En=00100 -> Stage_En, Stage_Idx=2 and Instr_Count frozen. Resumes at the same div_cnt phase.
- Interrupt rises while Stage_Idx=1 -> Irq_Pending=1 the next cycle. Irq_Ack=1 for one cycle with Stage_En=00001 after the wrap, then Irq_Pending=0. A second edge in the ack cycle -> Irq_Pending remains 1.
- CNT_W=2, run 5 instruction cycles -> Instr_Count 1, 2, 3, 0, 1. Asserting Reset_n=0 mid-cycle at Stage_Idx=3 -> all outputs return to their reset values on that edge.
- MIPS_SEQ_SINGLE_STEP_EN defined -> after the first wrap, Stage_En stays 00001 for 10 clocks. A one-clock Step pulse runs exactly one further instruction cycle.
